// File: rtl/send_unit.sv
// send_unit: takes one decoded send instruction, then streams words from a local
// 8-entry register file to the selected PE over a backpressured ready/valid port.
//
// Ports
//   clock, reset           : clock, asynchronous active-low reset
//   io_inst_*              : instruction handshake (dest_pe, reg_start_addr, data_length)
//   io_rf_wen/waddr/wdata  : register-file write port, usable in any state
//   io_out_valid/ready     : output beat handshake
//   io_out_data            : beat payload (registered)
//   io_out_pe_sel          : one-hot destination, zero while no beat is valid
//   io_out_last            : marks the final beat of an instruction
//   io_busy                : high while a stream is in progress
//
// Optional feature (macro SENDU_OUT_PARITY_EN): adds io_out_parity, the even
// parity (XOR reduction) of io_out_data, registered together with the data.
module send_unit #(
  parameter int DATA_W = 16,
  parameter int NUM_PE = 4
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              io_inst_valid,
  output logic              io_inst_ready,
  input  logic [1:0]        io_inst_dest_pe,
  input  logic [2:0]        io_inst_reg_start_addr,
  input  logic [2:0]        io_inst_data_length,
  input  logic              io_rf_wen,
  input  logic [2:0]        io_rf_waddr,
  input  logic [DATA_W-1:0] io_rf_wdata,
  output logic              io_out_valid,
  input  logic              io_out_ready,
  output logic [DATA_W-1:0] io_out_data,
  output logic [NUM_PE-1:0] io_out_pe_sel,
  output logic              io_out_last,
  output logic              io_busy
`ifdef SENDU_OUT_PARITY_EN
  ,
  output logic              io_out_parity
`endif
);

  localparam logic [0:0] S_IDLE = 1'b0;
  localparam logic [0:0] S_SEND = 1'b1;

  logic [0:0]                  state_q, state_d;
  logic [1:0]                  pe_q, pe_d;
  logic [2:0]                  addr_q, addr_d;
  logic [2:0]                  rem_q, rem_d;
  logic [DATA_W-1:0]           data_q, data_d;
  logic [7:0][DATA_W-1:0]      rf_q, rf_d;
  logic [2:0]                  nxt_addr;
  logic [NUM_PE-1:0]           pe_one;

  // 3-bit add wraps naturally, giving the mod-8 address walk
  assign nxt_addr = addr_q + 3'd1;
  assign pe_one   = {{(NUM_PE-1){1'b0}}, 1'b1};

  always_comb begin
    state_d = state_q;
    pe_d    = pe_q;
    addr_d  = addr_q;
    rem_d   = rem_q;
    data_d  = data_q;
    rf_d    = rf_q;

    if (io_rf_wen) rf_d[io_rf_waddr] = io_rf_wdata;

    // Loads read rf_q, so a write landing in the same cycle is not seen
    // by that load; the old word goes out and later loads get the new one.
    case (state_q)
      S_IDLE: begin
        if (io_inst_valid && io_inst_data_length != 3'd0) begin
          pe_d    = io_inst_dest_pe;
          addr_d  = io_inst_reg_start_addr;
          rem_d   = io_inst_data_length;
          data_d  = rf_q[io_inst_reg_start_addr];
          state_d = S_SEND;
        end
      end
      default: begin
        if (io_out_ready) begin
          if (rem_q == 3'd1) begin
            rem_d   = 3'd0;
            state_d = S_IDLE;
          end else begin
            addr_d = nxt_addr;
            rem_d  = rem_q - 3'd1;
            data_d = rf_q[nxt_addr];
          end
        end
      end
    endcase
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q <= S_IDLE;
      pe_q    <= '0;
      addr_q  <= '0;
      rem_q   <= '0;
      data_q  <= '0;
      rf_q    <= '0;
    end else begin
      state_q <= state_d;
      pe_q    <= pe_d;
      addr_q  <= addr_d;
      rem_q   <= rem_d;
      data_q  <= data_d;
      rf_q    <= rf_d;
    end
  end

`ifdef SENDU_OUT_PARITY_EN
  logic par_q, par_d;
  // follows data_d, so it only changes when a new word is loaded
  assign par_d = ^data_d;
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) par_q <= 1'b0;
    else        par_q <= par_d;
  end
  assign io_out_parity = par_q;
`endif

  // The beat is valid for the whole SEND state; all of these are decoded
  // from flops so they stay stable while the consumer stalls.
  assign io_inst_ready = (state_q == S_IDLE);
  assign io_busy       = (state_q == S_SEND);
  assign io_out_valid  = (state_q == S_SEND);
  assign io_out_data   = data_q;
  assign io_out_last   = io_out_valid && (rem_q == 3'd1);
  assign io_out_pe_sel = io_out_valid ? (pe_one << pe_q) : '0;

endmodule

// File: tb/tb_send_unit.sv
module tb_send_unit;
  localparam int DATA_W = 16;
  localparam int NUM_PE = 4;

  logic              clock = 1'b0;
  logic              reset = 1'b0;
  logic              io_inst_valid;
  logic              io_inst_ready;
  logic [1:0]        io_inst_dest_pe;
  logic [2:0]        io_inst_reg_start_addr;
  logic [2:0]        io_inst_data_length;
  logic              io_rf_wen;
  logic [2:0]        io_rf_waddr;
  logic [DATA_W-1:0] io_rf_wdata;
  logic              io_out_valid;
  logic              io_out_ready;
  logic [DATA_W-1:0] io_out_data;
  logic [NUM_PE-1:0] io_out_pe_sel;
  logic              io_out_last;
  logic              io_busy;
`ifdef SENDU_OUT_PARITY_EN
  logic              io_out_parity;
`endif

  send_unit #(.DATA_W(DATA_W), .NUM_PE(NUM_PE)) dut (
    .clock                  (clock),
    .reset                  (reset),
    .io_inst_valid          (io_inst_valid),
    .io_inst_ready          (io_inst_ready),
    .io_inst_dest_pe        (io_inst_dest_pe),
    .io_inst_reg_start_addr (io_inst_reg_start_addr),
    .io_inst_data_length    (io_inst_data_length),
    .io_rf_wen              (io_rf_wen),
    .io_rf_waddr            (io_rf_waddr),
    .io_rf_wdata            (io_rf_wdata),
    .io_out_valid           (io_out_valid),
    .io_out_ready           (io_out_ready),
    .io_out_data            (io_out_data),
    .io_out_pe_sel          (io_out_pe_sel),
    .io_out_last            (io_out_last),
    .io_busy                (io_busy)
`ifdef SENDU_OUT_PARITY_EN
    ,
    .io_out_parity          (io_out_parity)
`endif
  );

  always #5 clock = ~clock;

  int n_tests = 0;
  int n_fail  = 0;

  // Reference model: the register file as a plain array, the words still to
  // be sent as a queue of addresses, and the beat currently on offer.
  int m_rf [8];
  bit m_valid;
  int m_data;
  int m_pe;
  int m_q [$];
  int beats [$];
  int sels  [$];

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic model_clear();
    foreach (m_rf[i]) m_rf[i] = 0;
    m_valid = 0;
    m_data  = 0;
    m_pe    = 0;
    m_q.delete();
  endtask

  task automatic check_all();
    chk("out_valid", io_out_valid, m_valid);
    chk("inst_ready", io_inst_ready, !m_valid);
    chk("busy", io_busy, m_valid);
    chk("last", io_out_last, m_valid && m_q.size() == 0);
    chk("pe_sel", io_out_pe_sel, m_valid ? (64'd1 << m_pe) : 64'd0);
    if (m_valid) begin
      chk("out_data", io_out_data, m_data[DATA_W-1:0]);
`ifdef SENDU_OUT_PARITY_EN
      chk("parity", io_out_parity, ^m_data[DATA_W-1:0]);
`endif
    end
  endtask

  // One clock: check at the falling edge, advance the model with the inputs
  // that the DUT will sample, then drive-ready point just after the rising edge.
  task automatic step();
    int a;
    @(negedge clock);
    check_all();
    if (io_out_valid && io_out_ready) begin
      beats.push_back(int'(io_out_data));
      sels.push_back(int'(io_out_pe_sel));
    end
    if (m_valid) begin
      if (io_out_ready) begin
        if (m_q.size() == 0) m_valid = 0;
        else begin
          a = m_q.pop_front();
          m_data = m_rf[a];
        end
      end
    end else if (io_inst_valid && io_inst_data_length != 0) begin
      for (int k = 0; k < int'(io_inst_data_length); k++)
        m_q.push_back((int'(io_inst_reg_start_addr) + k) % 8);
      a = m_q.pop_front();
      m_data  = m_rf[a];
      m_pe    = int'(io_inst_dest_pe);
      m_valid = 1;
    end
    if (io_rf_wen) m_rf[io_rf_waddr] = int'(io_rf_wdata);
    @(posedge clock);
    #1;
  endtask

  task automatic run(input int n);
    repeat (n) step();
  endtask

  task automatic rf_write(input int a, input int d);
    io_rf_wen = 1; io_rf_waddr = a[2:0]; io_rf_wdata = d[DATA_W-1:0];
    step();
    io_rf_wen = 0;
  endtask

  task automatic send(input int pe, input int addr, input int len);
    io_inst_valid = 1;
    io_inst_dest_pe = pe[1:0];
    io_inst_reg_start_addr = addr[2:0];
    io_inst_data_length = len[2:0];
    step();
    io_inst_valid = 0;
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_valid"}, io_out_valid, 1'b0);
    chk({tag, "_last"}, io_out_last, 1'b0);
    chk({tag, "_sel"}, io_out_pe_sel, '0);
    chk({tag, "_data"}, io_out_data, '0);
    chk({tag, "_busy"}, io_busy, 1'b0);
`ifdef SENDU_OUT_PARITY_EN
    chk({tag, "_par"}, io_out_parity, 1'b0);
`endif
  endtask

  initial begin
    int first_data, first_sel;
    io_inst_valid = 0; io_inst_dest_pe = 0; io_inst_reg_start_addr = 0;
    io_inst_data_length = 0; io_rf_wen = 0; io_rf_waddr = 0; io_rf_wdata = 0;
    io_out_ready = 1;
    model_clear();

    // reset state
    #3;
    chk_reset_outputs("rst");
    chk("rst_inst_ready", io_inst_ready, 1'b1);
    #9 reset = 1;
    @(posedge clock); #1;

    // basic send
    rf_write(2, 'h0A); rf_write(3, 'h0B); rf_write(4, 'h0C);
    beats.delete(); sels.delete();
    send(1, 2, 3);
    run(4);
    chk("basic_n", beats.size(), 3);
    if (beats.size() == 3) begin
      chk("basic_b0", beats[0], 'h0A);
      chk("basic_b1", beats[1], 'h0B);
      chk("basic_b2", beats[2], 'h0C);
      chk("basic_sel", sels[0], 4'b0010);
    end

    // wrap-around
    for (int i = 0; i < 8; i++) rf_write(i, i + 'h10);
    beats.delete(); sels.delete();
    send(3, 6, 4);
    run(5);
    chk("wrap_n", beats.size(), 4);
    if (beats.size() == 4) begin
      chk("wrap_b0", beats[0], 'h16);
      chk("wrap_b1", beats[1], 'h17);
      chk("wrap_b2", beats[2], 'h10);
      chk("wrap_b3", beats[3], 'h11);
      chk("wrap_sel", sels[3], 4'b1000);
    end

    // backpressure
    io_out_ready = 0;
    send(2, 3, 2);
    first_data = int'(io_out_data);
    first_sel  = int'(io_out_pe_sel);
    for (int i = 0; i < 5; i++) begin
      chk("bp_data", io_out_data, 'h13);
      chk("bp_hold", io_out_data, first_data[DATA_W-1:0]);
      chk("bp_sel", io_out_pe_sel, first_sel[NUM_PE-1:0]);
      chk("bp_last", io_out_last, 1'b0);
      chk("bp_ready", io_inst_ready, 1'b0);
      step();
    end
    io_out_ready = 1;
    run(3);
    chk("bp_done", io_inst_ready, 1'b1);

    // zero length, then an instruction on the very next cycle
    send(0, 5, 0);
    chk("zl_valid", io_out_valid, 1'b0);
    chk("zl_busy", io_busy, 1'b0);
    send(0, 5, 1);
    chk("zl_second", io_out_valid, 1'b1);
    chk("zl_data", io_out_data, 'h15);
    run(2);

    // write collision: rf[1] is loaded on the edge where beat 0 is taken
    rf_write(0, 'h100); rf_write(1, 'h101); rf_write(2, 'h102);
    beats.delete();
    send(1, 0, 3);
    io_rf_wen = 1; io_rf_waddr = 1; io_rf_wdata = 'hFF;
    step();
    io_rf_wen = 0;
    run(3);
    chk("coll_n", beats.size(), 3);
    if (beats.size() == 3) chk("coll_old", beats[1], 'h101);
    beats.delete();
    send(0, 1, 1);
    run(2);
    chk("coll_new_n", beats.size(), 1);
    if (beats.size() == 1) chk("coll_new", beats[0], 'hFF);

`ifdef SENDU_OUT_PARITY_EN
    rf_write(5, 'h0007);
    send(0, 5, 1);
    chk("par_7", io_out_parity, 1'b1);
    run(2);
`endif

    // reset during the second beat of a len=5 send
    send(2, 0, 5);
    step();
    chk("mid_valid_pre", io_out_valid, 1'b1);
    #1 reset = 0;
    #1;
    chk_reset_outputs("mid");
    model_clear();
    @(negedge clock); @(posedge clock);
    #2 reset = 1;
    #1;
    chk("mid_ready", io_inst_ready, 1'b1);
    @(posedge clock); #1;
    beats.delete();
    send(0, 0, 7);
    run(7);
    send(0, 7, 1);
    run(2);
    chk("mid_rf_n", beats.size(), 8);
    foreach (beats[i]) chk("mid_rf_zero", beats[i], 0);

    // randomized traffic against the model
    for (int c = 0; c < 400; c++) begin
      io_inst_valid = ($urandom_range(0, 1) == 1);
      io_inst_dest_pe = 2'($urandom);
      io_inst_reg_start_addr = 3'($urandom);
      io_inst_data_length = 3'($urandom);
      io_rf_wen = ($urandom_range(0, 9) < 3);
      io_rf_waddr = 3'($urandom);
      io_rf_wdata = DATA_W'($urandom);
      io_out_ready = ($urandom_range(0, 9) < 7);
      step();
    end
    io_inst_valid = 0; io_rf_wen = 0; io_out_ready = 1;
    run(10);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule

// File: doc/send_unit.md
Name: send_unit

Overview:
- Execution stage directly downstream of the instruction decoder.
- Consumes one decoded send instruction (dest_pe, reg_start_addr, data_length) over a ready/valid handshake.
- Streams data_length consecutive words from a local 8-entry register file to the selected PE over a backpressured ready/valid output.
- One instruction in flight at a time; a second instruction is not accepted until the current one finishes.

Parameters:
- DATA_W, 16, width of each register-file word and of the output data.
- NUM_PE, 4, number of destination PEs; width of the one-hot select (dest_pe is 2 bits).

Ports:
- clock  in  1  single clock; all state updates on the rising edge.
- reset  in  1  asynchronous, active-low reset (asserts immediately when low; deassertion synchronous to clock).
- io_inst_valid  in  1  decoded instruction valid.
- io_inst_ready  out  1  unit can accept an instruction.
- io_inst_dest_pe  in  2  destination PE index.
- io_inst_reg_start_addr  in  3  first register-file address.
- io_inst_data_length  in  3  number of words to send (0..7).
- io_rf_wen  in  1  register-file write enable.
- io_rf_waddr  in  3  register-file write address.
- io_rf_wdata  in  DATA_W  register-file write data.
- io_out_valid  out  1  output beat valid.
- io_out_ready  in  1  consumer accepts beat.
- io_out_data  out  DATA_W  beat payload.
- io_out_pe_sel  out  NUM_PE  one-hot destination; all zero when io_out_valid=0.
- io_out_last  out  1  final beat of the instruction.
- io_busy  out  1  high while in SEND.

Behaviour:
- Reset values:
  - FSM=IDLE.
  - io_out_valid=0, io_out_last=0, io_out_pe_sel=0, io_out_data=0, io_busy=0.
  - All register-file entries 0.
  - Internal counters 0.
- States: IDLE, SEND.
- IDLE:
  - io_inst_ready=1.
  - Handshake when io_inst_valid && io_inst_ready.
  - Accepted with length L=0: no-op; stay in IDLE; no beat emitted.
  - Accepted with L>0:
    - Latch pe and addr=start_addr; set remaining=L.
    - Load output register with rf[start_addr]; go to SEND.
    - io_out_valid=1 on the next cycle (latency 1 clock from accept to first beat).
- SEND:
  - io_inst_ready=0 and io_busy=1.
  - io_out_valid is held until the beat is accepted.
  - io_out_data, io_out_pe_sel and io_out_last stay stable while valid && !ready.
  - On beat accept (valid && ready) with remaining>1:
    - addr=(addr+1) mod 8; remaining-1.
    - Load rf[new addr] into the output register, so the next beat is valid the following cycle.
    - Sustained throughput is 1 beat/cycle.
  - On beat accept with remaining==1: io_out_valid=0 next cycle; return to IDLE; io_inst_ready=1 that same next cycle.
- io_out_last=1 exactly when io_out_valid=1 and remaining==1.
- Address arithmetic is 3-bit wrap-around: start 6, length 4 reads 6,7,0,1.
- Register-file write:
  - Always allowed, in any state.
  - A write to the address being loaded in the same cycle is not visible in that load (the old value is sent).
  - Later loads see the new value.
- io_out_pe_sel = 1<<pe while valid.
- Reset mid-operation aborts the instruction immediately: outputs and register file return to reset values; the partial stream is not completed.
- io_out_ready is ignored while io_out_valid=0.

Optional Feature:
- Macro: SENDU_OUT_PARITY_EN.
- Defined: extra output port io_out_parity (1 bit) = XOR-reduction (even parity) of io_out_data.
  - Registered alongside the data; 0 at reset.
  - Stable under backpressure.
- Undefined: port and logic absent; all other behaviour identical.

Test Plan:
- Basic send:
  - Stimulus: write rf[2..4]=0x0A,0x0B,0x0C; issue pe=1, addr=2, len=3 with out_ready=1.
  - Required: beats 0x0A,0x0B,0x0C on 3 consecutive cycles starting 1 cycle after accept; pe_sel=4'b0010; last only on 0x0C; inst_ready=1 the cycle after.
- Wrap:
  - Stimulus: rf[i]=i+0x10; pe=3, addr=6, len=4.
  - Required: beats 0x16,0x17,0x10,0x11; pe_sel=4'b1000.
- Backpressure:
  - Stimulus: len=2; hold out_ready=0 for 5 cycles after the first valid.
  - Required: first beat data/last/pe_sel unchanged for all 5 cycles; inst_ready=0 throughout; completes after ready is raised.
- Zero length:
  - Stimulus: len=0 accepted.
  - Required: io_out_valid stays 0; busy stays 0; a second instruction is accepted the next cycle.
- Write collision:
  - Stimulus: during a send from addr 0 with len 3, write rf[1]=0xFF in the same cycle rf[1] is loaded.
  - Required: the old rf[1] value is sent; a subsequent instruction reading addr 1 gets 0xFF.
- Reset mid-stream:
  - Stimulus: assert reset (low) during the second beat of a len=5 send.
  - Required: outputs 0 immediately; after release the unit is in IDLE with inst_ready=1 and the register file reads 0.
  - With SENDU_OUT_PARITY_EN: additionally check parity=1 for data 0x0007.
